// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed when Start is accepted and committed to HI/LO after a fixed latency.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        HLWrite,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   hi_n;
  logic [31:0]   lo_n;

  logic [63:0] prod;
  logic        is_signed;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] result;

  assign is_signed = ~MDOp[0];

  // One unsigned divider serves both DIV and DIVU by operating on magnitudes.
  always_comb begin
    neg_a = is_signed & A[31];
    neg_b = is_signed & B[31];
    mag_a = neg_a ? (~A + 32'd1) : A;
    mag_b = neg_b ? (~B + 32'd1) : B;
    quo_u = 32'd0;
    rem_u = 32'd0;
    if (mag_b != 32'd0) begin
      quo_u = mag_a / mag_b;
      rem_u = mag_a % mag_b;
    end
    quo = (neg_a ^ neg_b) ? (~quo_u + 32'd1) : quo_u;
    rem = neg_a ? (~rem_u + 32'd1) : rem_u;
  end

  always_comb begin
    if (is_signed)
      prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    else
      prod = {32'd0, A} * {32'd0, B};
  end

  always_comb begin
    result = 64'd0;
    if (!MDOp[1])
      result = prod;
    else if (B == 32'd0)
      result = {A, 32'hFFFF_FFFF};
    else
      result = {rem, quo};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      Busy  <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      hi_n  <= 32'd0;
      lo_n  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start && !Flush) begin
            // A concurrent HLWrite is dropped; reserved opcodes do nothing.
            if (!MDOp[2]) begin
              hi_n  <= result[63:32];
              lo_n  <= result[31:0];
              count <= MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              Busy  <= 1'b1;
              state <= BUSY;
            end
          end else if (HLWrite && !Flush) begin
            if (MDOp == 3'b100)
              HI <= A;
            else if (MDOp == 3'b101)
              LO <= A;
          end
        end
        BUSY: begin
          count <= count - 1'b1;
          if (count <= CW'(1)) begin
            HI    <= hi_n;
            LO    <= lo_n;
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: table of mult/div vectors plus hand-written corner sequences.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic        HLWrite;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int total_cnt;
  int pass_cnt;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .HLWrite(HLWrite), .MDOp(MDOp),
    .A(A), .B(B), .Flush(Flush), .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Issue one op, count Busy cycles, verify HI/LO hold, return measured length.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke_mtlo, output int busy_len);
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0 = HI;
    lo0 = LO;
    @(negedge clk);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0;
    busy_len = 0;
    while (Busy && busy_len < 50) begin
      check("hold_hi", HI, hi0);
      check("hold_lo", LO, lo0);
      busy_len++;
      if (poke_mtlo && busy_len == 2) begin
        HLWrite = 1'b1; MDOp = 3'b101; A = 32'h1234;
      end else begin
        HLWrite = 1'b0;
      end
      @(negedge clk);
    end
    HLWrite = 1'b0;
  endtask

  initial begin
    int len;
    total_cnt = 0;
    pass_cnt  = 0;
    vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'd2,          5,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'd2,          5,  32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{3'b010, 32'hFFFF_FFF9, 32'd2,          10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'b011, 32'd7,         32'd0,          10, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF,  10, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{3'b010, 32'd7,         32'd0,          10, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[6]  = '{3'b011, 32'hFFFF_FFF9, 32'd2,          10, 32'h0000_0001, 32'h7FFF_FFFC};
    vecs[7]  = '{3'b000, 32'h0001_0000, 32'h0001_0000,  5,  32'h0000_0001, 32'h0000_0000};
    vecs[8]  = '{3'b010, 32'd7,         32'hFFFF_FFFE,  10, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9]  = '{3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB,  5,  32'h0000_0000, 32'h0000_000F};
    vecs[10] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5,  32'hFFFF_FFFE, 32'h0000_0001};

    reset = 1'b0; Start = 1'b0; HLWrite = 1'b0; MDOp = 3'b000;
    A = 32'd0; B = 32'd0; Flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, len);
      check($sformatf("v%0d_busy_len", i), len, vecs[i].cycles);
      check($sformatf("v%0d_hi", i), HI, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), LO, vecs[i].exp_lo);
      $display("vec %0d op=%0d a=%08h b=%08h -> busy=%0d hi=%08h lo=%08h",
               i, vecs[i].op, vecs[i].a, vecs[i].b, len, HI, LO);
    end

    // Start under Flush: nothing happens.
    @(negedge clk);
    Start = 1'b1; Flush = 1'b1; MDOp = 3'b000; A = 32'd3; B = 32'd3;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    check("flush_busy", {31'd0, Busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("flush_hi", HI, 32'hFFFF_FFFE);
    check("flush_lo", LO, 32'h0000_0001);
    $display("flush start: busy=%0d hi=%08h lo=%08h", Busy, HI, LO);

    // MTLO during BUSY is dropped.
    run_op(3'b001, 32'd6, 32'd7, 1'b1, len);
    check("mtlo_busy_len", len, 5);
    check("mtlo_busy_hi", HI, 32'd0);
    check("mtlo_busy_lo", LO, 32'd42);
    $display("mtlo during busy: hi=%08h lo=%08h", HI, LO);

    // MTHI in IDLE lands on the next edge.
    @(negedge clk);
    HLWrite = 1'b1; MDOp = 3'b100; A = 32'hABCD;
    @(negedge clk);
    HLWrite = 1'b0;
    check("mthi_hi", HI, 32'hABCD);
    check("mthi_lo", LO, 32'd42);
    $display("mthi: hi=%08h lo=%08h", HI, LO);

    // Start and HLWrite together: Start wins.
    @(negedge clk);
    Start = 1'b1; HLWrite = 1'b1; MDOp = 3'b000; A = 32'd4; B = 32'd5;
    @(negedge clk);
    Start = 1'b0; HLWrite = 1'b0;
    check("both_busy", {31'd0, Busy}, 32'd1);
    repeat (5) @(negedge clk);
    check("both_hi", HI, 32'd0);
    check("both_lo", LO, 32'd20);
    $display("start+hlwrite: hi=%08h lo=%08h", HI, LO);

    // Reset in the middle of a DIV.
    @(negedge clk);
    HLWrite = 1'b1; MDOp = 3'b100; A = 32'h5555;
    @(negedge clk);
    HLWrite = 1'b0;
    Start = 1'b1; MDOp = 3'b010; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, Busy}, 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_after_busy", {31'd0, Busy}, 32'd0);
    check("rst_after_hi", HI, 32'd0);
    check("rst_after_lo", LO, 32'd0);
    $display("reset mid-div: busy=%0d hi=%08h lo=%08h", Busy, HI, LO);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
